add_seq_stage: RTL and testbench
================================

# add_seq_stage

Multi-word add sequencer that sits directly upstream of the combinational adder core and downstream of any operand source. It accepts WIDTH-bit operand word pairs over a valid/ready stream and registers them into the core. It waits a programmable number of settle cycles for the ripple path, then captures sum and carry-out into an output stream. Carry is chained between consecutive beats of a packet, so arbitrarily wide additions run as a sequence of WIDTH-bit beats.

## Interface
- WIDTH, 16, operand/sum word width; passed to the adder core.
- SETTLE, 2, cycles from operand register load to result capture; legal range 1..15.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  sequencer can accept a beat.
- in_a  in  [WIDTH:1]  operand A word.
- in_b  in  [WIDTH:1]  operand B word.
- in_cin  in  1  packet carry-in; sampled on the first beat of a packet only.
- in_last  in  1  final beat of packet.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts result.
- out_sum  out  [WIDTH:1]  sum word.
- out_cout  out  1  carry-out of this word.
- out_last  out  1  copy of in_last for this beat.
- busy  out  1  high whenever state is not IDLE.

## Operation
- FSM states: IDLE, SETTLE, HOLD.
- IDLE: in_ready=1.
  - On in_valid, load in_a, in_b, in_last into operand registers.
  - Load core carry-in: in_cin if first_flag=1, else carry_reg.
  - Load settle counter with SETTLE-1, then go to SETTLE.
- SETTLE: in_ready=0. The core is driven only from the operand registers.
  - When counter=0, capture the core S into out_sum, Cout into out_cout, and the stored last into out_last. Set out_valid and go to HOLD.
  - Otherwise decrement the counter.
- HOLD: out_valid=1, and all outputs stay stable until out_ready=1. On that handshake:
  - Clear out_valid.
  - If out_last=1: first_flag←1 and carry_reg←0.
  - Else: first_flag←0 and carry_reg←out_cout.
  - Go to IDLE.
- in_cin is ignored on non-first beats.
- Sum arithmetic per beat is modulo 2^WIDTH. The carry across beats is exact, so a packet of N beats computes an N·WIDTH-bit add.
- Reset values: state IDLE, out_valid 0, out_sum 0, out_cout 0, out_last 0, first_flag 1, carry_reg 0, counter 0. busy 0 and in_ready 1 after reset.
- Reset in any state aborts the packet. The next accepted beat is treated as a first beat.

## Timing
- Latency: an input handshake at edge k produces out_valid high from edge k+SETTLE.
- No overlap between beats. With out_ready tied high, the minimum beat period is SETTLE+2 cycles.
- in_ready is combinational from state only, never from in_valid.
- out_valid must not depend on out_ready.
- The core sees stable operands for a full SETTLE cycles before capture. Core input changes occur only at the IDLE accept edge.

## Structure
- Shared package add_seq_pkg holds:
  - the state enum (IDLE, SETTLE, HOLD);
  - the settle-counter width constant (4 bits);
  - a SETTLE range-check constant.
- One sub-module is natural: the existing RCA core instanced at WIDTH, fed from the operand and carry-in registers.
- The FSM, counter and output registers stay in add_seq_stage.

## Test plan
Use WIDTH=16 and SETTLE=2 unless stated otherwise.
- **Single beat:** a=0x1234, b=0x0FF0, cin=0, last=1 → out_sum=0x2224, out_cout=0, out_last=1. out_valid rises exactly 2 edges after accept.
- **Carry chain:** beat0 a=0xFFFF, b=0x0001, cin=0; beat1 a=0x0000, b=0x0000, last=1 → beat0 sum 0x0000 with cout=1; beat1 sum 0x0001 with cout=0.
- **cin ignored mid-packet:** beat0 a=0x8000, b=0x8000, cin=0; beat1 a=0, b=0, in_cin=1, last=1 → beat1 sum 0x0001 from the chained carry. The in_cin=1 is not applied, or the sum would be 0x0002.
- **Backpressure:** hold out_ready=0 for 5 cycles in HOLD → out_sum, out_cout, out_last stable and in_ready=0 throughout. After release, the next packet's first beat a=1, b=1, cin=1 gives 0x0003 with carry_reg cleared.
- **Reset mid-operation:** assert rst during SETTLE of beat0 (a=0xFFFF, b=1) → next cycle out_valid=0, state IDLE. A following beat a=0, b=0, cin=0 gives 0x0000 with no stale carry.
- **Throughput:** SETTLE=1, in_valid and out_ready held high, 4-beat packet → one accept every 3 cycles, all 4 results in order, out_last only on beat 3.

Source files
------------

// File: rtl/add_seq_pkg.sv
// Shared types and constants for the multi-word add sequencer.
package add_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StHold
  } add_seq_state_e;

  localparam int unsigned CntW      = 4;
  localparam int unsigned SettleMin = 1;
  localparam int unsigned SettleMax = (1 << CntW) - 1;

  function automatic bit settle_in_range(input int unsigned settle);
    return (settle >= SettleMin) && (settle <= SettleMax);
  endfunction

endpackage

// File: rtl/add_seq_stage_if.sv
// Operand-in / result-out stream pair of the add sequencer.
interface add_seq_stage_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH:1]   in_a;
    logic [WIDTH:1]   in_b;
    logic             in_cin;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:1]   out_sum;
    logic             out_cout;
    logic             out_last;

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_last
    );

    modport master (
        output in_valid, in_a, in_b, in_cin, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_last
    );
endinterface

// File: rtl/add_seq_stage_rca.sv
// Combinational ripple-carry adder core; its ripple path is what the sequencer waits on.
module add_seq_stage_rca #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH:1] a_i,
    input  logic [WIDTH:1] b_i,
    input  logic           cin_i,
    output logic [WIDTH:1] s_o,
    output logic           cout_o
);
    logic [WIDTH+1:1] c;

    always_comb begin
        c    = '0;
        s_o  = '0;
        c[1] = cin_i;
        for (int i = 1; i <= WIDTH; i++) begin
            s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
            c[i + 1] = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
        end
        cout_o = c[WIDTH + 1];
    end
endmodule

// File: rtl/add_seq_stage.sv
// Multi-word add sequencer: registers operand beats into the RCA core, waits SETTLE
// cycles, captures sum/carry and chains the carry across the beats of a packet.
module add_seq_stage
    import add_seq_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned SETTLE = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    add_seq_stage_if.slave         bus,
    output logic                   busy
);
    if (!settle_in_range(SETTLE)) begin : gen_settle_check
        $error("add_seq_stage: SETTLE out of range 1..15");
    end

    add_seq_state_e state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [WIDTH:1]  a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic            cin_q, cin_d, last_q, last_d;
    logic            cout_q, cout_d, olast_q, olast_d, ovalid_q, ovalid_d;
    logic            first_q, first_d, carry_q, carry_d;
    logic [WIDTH:1]  core_s;
    logic            core_cout;

    // The core only ever sees registered operands, so its inputs move at the accept edge only.
    add_seq_stage_rca #(
        .WIDTH (WIDTH)
    ) u_rca (
        .a_i    (a_q),
        .b_i    (b_q),
        .cin_i  (cin_q),
        .s_o    (core_s),
        .cout_o (core_cout)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        cin_d    = cin_q;
        last_d   = last_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        olast_d  = olast_q;
        ovalid_d = ovalid_q;
        first_d  = first_q;
        carry_d  = carry_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    last_d  = bus.in_last;
                    cin_d   = first_q ? bus.in_cin : carry_q;
                    cnt_d   = CntW'(SETTLE - 1);
                    state_d = StSettle;
                end
            end
            StSettle: begin
                if (cnt_q == '0) begin
                    sum_d    = core_s;
                    cout_d   = core_cout;
                    olast_d  = last_q;
                    ovalid_d = 1'b1;
                    state_d  = StHold;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StHold: begin
                if (bus.out_ready) begin
                    ovalid_d = 1'b0;
                    first_d  = olast_q;
                    carry_d  = olast_q ? 1'b0 : cout_q;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cin_q    <= 1'b0;
            last_q   <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            olast_q  <= 1'b0;
            ovalid_q <= 1'b0;
            first_q  <= 1'b1;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cin_q    <= cin_d;
            last_q   <= last_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            olast_q  <= olast_d;
            ovalid_q <= ovalid_d;
            first_q  <= first_d;
            carry_q  <= carry_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = ovalid_q;
    assign bus.out_sum   = sum_q;
    assign bus.out_cout  = cout_q;
    assign bus.out_last  = olast_q;
    assign busy          = (state_q != StIdle);
endmodule

// File: tb/tb_add_seq_stage.sv
// Bench for add_seq_stage: directed and random packets checked against a wide-integer add model.
module tb_add_seq_stage;
    localparam int unsigned W = 16;

    logic clk = 1'b0;
    logic rst;
    logic busy0, busy1;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Current packet: operand words, packet carry-in, and junk cin for non-first beats.
    logic [W-1:0] pa [4];
    logic [W-1:0] pb [4];
    logic         pcin;
    logic         pmid [4];

    always #5 clk = ~clk;

    add_seq_stage_if #(.WIDTH(W)) if0 ();
    add_seq_stage_if #(.WIDTH(W)) if1 ();

    add_seq_stage #(.WIDTH(W), .SETTLE(2)) u_dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (if0.slave),
        .busy (busy0)
    );

    add_seq_stage #(.WIDTH(W), .SETTLE(1)) u_dut1 (
        .clk  (clk),
        .rst  (rst),
        .bus  (if1.slave),
        .busy (busy1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Beat i of a packet: that word of the full (i+1)-word sum, plus the carry out of it.
    function automatic logic [W:0] model_beat(input int i);
        logic [79:0] ta, tb, part;
        ta = '0;
        tb = '0;
        for (int j = 0; j <= i; j++) begin
            ta[W*j +: W] = pa[j];
            tb[W*j +: W] = pb[j];
        end
        part = ta + tb + {79'd0, pcin};
        return {part[W*(i+1)], part[W*i +: W]};
    endfunction

    // One beat on if0; hold_cyc extra cycles with out_ready low before the handshake.
    task automatic run_beat(input int i, input int n, input int hold_cyc);
        int          waitc;
        int          lat;
        logic [W:0]  exp;
        logic [W-1:0] s0;
        logic        c0, l0;
        @(negedge clk);
        if0.in_a      = pa[i];
        if0.in_b      = pb[i];
        if0.in_cin    = (i == 0) ? pcin : pmid[i];
        if0.in_last   = (i == n - 1);
        if0.in_valid  = 1'b1;
        if0.out_ready = 1'b0;
        waitc = 0;
        while (!if0.in_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        if (waitc >= 50) check_eq("in_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if0.in_valid = 1'b0;
        lat = 0;
        while (!if0.out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq("latency", lat, 2);
        exp = model_beat(i);
        check_eq("sum", 32'(if0.out_sum), 32'(exp[W-1:0]));
        check_eq("cout", 32'(if0.out_cout), 32'(exp[W]));
        check_eq("last", 32'(if0.out_last), 32'(i == n - 1));
        s0 = if0.out_sum;
        c0 = if0.out_cout;
        l0 = if0.out_last;
        repeat (hold_cyc) begin
            @(posedge clk);
            #1;
            check_eq("hold_valid", 32'(if0.out_valid), 32'd1);
            check_eq("hold_in_ready", 32'(if0.in_ready), 32'd0);
            check_eq("hold_stable", {15'd0, l0, c0, s0},
                     {15'd0, if0.out_last, if0.out_cout, if0.out_sum});
        end
        @(negedge clk);
        if0.out_ready = 1'b1;
        @(posedge clk);
        #1;
        if0.out_ready = 1'b0;
        check_eq("valid_cleared", 32'(if0.out_valid), 32'd0);
    endtask

    task automatic run_packet(input int n, input int hold_cyc);
        for (int i = 0; i < n; i++) run_beat(i, n, hold_cyc);
    endtask

    task automatic clear_packet();
        for (int i = 0; i < 4; i++) begin
            pa[i]   = '0;
            pb[i]   = '0;
            pmid[i] = 1'b0;
        end
        pcin = 1'b0;
    endtask

    task automatic throughput_test();
        int         acc_cyc [4];
        logic [W+1:0] res [4];
        int         nacc, nres, idx;
        logic       acc;
        logic [W:0] exp;
        for (int i = 0; i < 4; i++) begin
            pa[i]   = W'($urandom);
            pb[i]   = W'($urandom);
            pmid[i] = 1'($urandom);
        end
        pcin = 1'($urandom);
        nacc = 0;
        nres = 0;
        idx  = 0;
        @(negedge clk);
        if1.in_a      = pa[0];
        if1.in_b      = pb[0];
        if1.in_cin    = pcin;
        if1.in_last   = 1'b0;
        if1.in_valid  = 1'b1;
        if1.out_ready = 1'b1;
        for (int c = 0; c < 60 && nres < 4; c++) begin
            acc = if1.in_valid && if1.in_ready;
            if (if1.out_valid && if1.out_ready) begin
                res[nres] = {if1.out_last, if1.out_cout, if1.out_sum};
                nres++;
            end
            @(posedge clk);
            #1;
            if (acc) begin
                acc_cyc[nacc] = c;
                nacc++;
                idx++;
                if (idx < 4) begin
                    if1.in_a    = pa[idx];
                    if1.in_b    = pb[idx];
                    if1.in_cin  = pmid[idx];
                    if1.in_last = (idx == 3);
                end else begin
                    if1.in_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        check_eq("tp_results", nres, 4);
        check_eq("tp_accepts", nacc, 4);
        for (int i = 1; i < nacc; i++) check_eq("tp_period", acc_cyc[i] - acc_cyc[i-1], 3);
        for (int i = 0; i < nres; i++) begin
            exp = model_beat(i);
            check_eq("tp_sum", 32'(res[i][W-1:0]), 32'(exp[W-1:0]));
            check_eq("tp_cout", 32'(res[i][W]), 32'(exp[W]));
            check_eq("tp_last", 32'(res[i][W+1]), 32'(i == 3));
        end
    endtask

    initial begin
        int n;
        if0.in_valid  = 1'b0;
        if0.in_a      = '0;
        if0.in_b      = '0;
        if0.in_cin    = 1'b0;
        if0.in_last   = 1'b0;
        if0.out_ready = 1'b0;
        if1.in_valid  = 1'b0;
        if1.in_a      = '0;
        if1.in_b      = '0;
        if1.in_cin    = 1'b0;
        if1.in_last   = 1'b0;
        if1.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready", 32'(if0.in_ready), 32'd1);
        check_eq("rst_busy", 32'(busy0), 32'd0);
        check_eq("rst_out_valid", 32'(if0.out_valid), 32'd0);
        check_eq("rst_outputs", {15'd0, if0.out_last, if0.out_cout, if0.out_sum}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single beat.
        clear_packet();
        pa[0] = 16'h1234;
        pb[0] = 16'h0FF0;
        run_packet(1, 0);

        // Carry chain.
        clear_packet();
        pa[0] = 16'hFFFF;
        pb[0] = 16'h0001;
        run_packet(2, 0);

        // cin on a non-first beat must be ignored.
        clear_packet();
        pa[0]   = 16'h8000;
        pb[0]   = 16'h8000;
        pmid[1] = 1'b1;
        run_packet(2, 0);

        // Backpressure, then a fresh packet with cin=1.
        clear_packet();
        pa[0] = 16'hFFFF;
        pb[0] = 16'hFFFF;
        run_packet(1, 5);
        clear_packet();
        pa[0] = 16'h0001;
        pb[0] = 16'h0001;
        pcin  = 1'b1;
        run_packet(1, 0);

        // Reset during SETTLE of a non-final beat aborts the packet.
        @(negedge clk);
        if0.in_a     = 16'hFFFF;
        if0.in_b     = 16'h0001;
        if0.in_cin   = 1'b0;
        if0.in_last  = 1'b0;
        if0.in_valid = 1'b1;
        @(posedge clk);
        #1;
        if0.in_valid = 1'b0;
        check_eq("settle_busy", 32'(busy0), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("abort_out_valid", 32'(if0.out_valid), 32'd0);
        check_eq("abort_idle", 32'(if0.in_ready), 32'd1);
        check_eq("abort_busy", 32'(busy0), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        clear_packet();
        run_packet(1, 0);

        // Random packets.
        for (int p = 0; p < 8; p++) begin
            n = $urandom_range(1, 4);
            for (int i = 0; i < 4; i++) begin
                pa[i]   = W'($urandom);
                pb[i]   = W'($urandom);
                pmid[i] = 1'($urandom);
            end
            if (p == 0) begin
                for (int i = 0; i < 4; i++) pa[i] = 16'hFFFF;
            end
            pcin = 1'($urandom);
            run_packet(n, $urandom_range(0, 2));
        end

        throughput_test();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
